sne_sram_arbiter: RTL and testbench
===================================

Name: sne_sram_arbiter

Overview:
- Shares one single-port sne_sram instance between NUM_REQ requesters (e.g. the event engine and the config/debug bus) using round-robin arbitration.
- Returns read data to the winning requester with an aligned valid strobe.
- Owns the SRAM low-power control: drives power_sleep after a programmable idle period and sequences wake-up before granting again.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DATA_WIDTH, 8, SRAM word width. Must match the sne_sram instance.
- NUM_WORDS, 32, SRAM depth. ADDR_WIDTH = $clog2(NUM_WORDS) is a localparam.
- IDLE_CYCLES, 16, consecutive idle cycles before sleep (>=1).
- WAKE_CYCLES, 4, cycles spent in WAKE before grants resume (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- sleep_en_i  in  1  enables automatic sleep entry
- req_i  in  NUM_REQ  per-requester request
- we_i  in  NUM_REQ  per-requester write enable (1 = write)
- addr_i  in  NUM_REQ x ADDR_WIDTH  per-requester address
- wdata_i  in  NUM_REQ x DATA_WIDTH  per-requester write data
- be_i  in  NUM_REQ x DATA_WIDTH  per-requester bit enables
- gnt_o  out  NUM_REQ  one-hot grant, combinational
- rvalid_o  out  NUM_REQ  read-data valid, one-hot, registered
- rdata_o  out  DATA_WIDTH  read data, shared by all requesters
- sleeping_o  out  1  high in SLEEP and WAKE
- mem_req_o  out  1  to SRAM req_i
- mem_we_o  out  1  to SRAM we_i
- mem_addr_o  out  ADDR_WIDTH  to SRAM addr_i
- mem_wdata_o  out  DATA_WIDTH  to SRAM wdata_i
- mem_be_o  out  DATA_WIDTH  to SRAM be_i
- mem_rdata_i  in  DATA_WIDTH  from SRAM rdata_o
- mem_power_sleep_o  out  1  to SRAM power_sleep
- mem_power_gate_o  out  1  to SRAM power_gate; constant 0 (reserved)

Behaviour:
- Reset values:
  - state = ACTIVE; rr pointer = 0; idle and wake counters = 0.
  - rvalid_o = 0; mem_power_sleep_o = 0; sleeping_o = 0.
  - Combinational outputs follow from this state: gnt_o = 0 and mem_req_o = 0 when req_i = 0.
- Arbitration (ACTIVE only):
  - Winner = first asserted req_i at or after the pointer, searching upward with wrap from NUM_REQ-1 to 0.
  - gnt_o[winner] = 1 in the same cycle. mem_req_o = 1, and mem_we/addr/wdata/be are muxed from the winner.
  - On a grant, pointer <= (winner+1) mod NUM_REQ. With no grant, the pointer holds.
  - Requesters hold req_i and payload stable until granted; a deasserted, ungranted request is simply dropped.
  - Back-to-back grants every cycle are allowed; a grant is a complete transfer.
- Read return:
  - A read granted in cycle t gives rvalid_o[winner] = 1 in cycle t+1.
  - rdata_o = mem_rdata_i at all times; it is meaningful only while any rvalid_o bit is set.
  - Writes produce no rvalid.
  - A read granted in t+1 does not disturb the data returned in t+1.
- Idle counter:
  - Counts consecutive ACTIVE cycles with req_i = 0 and rvalid_o = 0. Any request or pending rvalid clears it.
  - Saturates at IDLE_CYCLES.
- FSM:
  - ACTIVE -> SLEEP when sleep_en_i = 1 and the idle count reaches IDLE_CYCLES. Takes effect on the next edge; mem_power_sleep_o = 1 from the first SLEEP cycle.
  - SLEEP: gnt_o = 0, mem_req_o = 0, mem_power_sleep_o = 1. SLEEP -> WAKE when |req_i or sleep_en_i = 0.
  - WAKE: mem_power_sleep_o = 0; grants stay blocked. The wake counter counts 1..WAKE_CYCLES, then WAKE -> ACTIVE and the counter clears.
  - The first grant is possible in the first ACTIVE cycle. Requests arriving in SLEEP/WAKE are held by the requester, not lost.
- Simultaneous events: reaching the idle threshold in the same cycle as a new request gives no sleep (the request clears the idle count first). sleep_en_i toggling in WAKE has no effect.
- Reset mid-operation: all state returns to reset values, pending rvalid is discarded, SRAM contents are untouched.

Decomposition:
- Package sne_sram_arb_pkg:
  - state enum sram_arb_state_e {ACTIVE, SLEEP, WAKE}.
  - Default parameter constants.
- Sub-module sne_rr_arbiter: parameter N; req/pointer in, one-hot gnt and winner index out. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single requester 0 writes addr 5 = 0xA5 (be 0xFF), then reads addr 5 -> gnt_o = 01 in both cycles; rvalid_o = 01 one cycle after the read; rdata_o = 0xA5.
- req_i = 11 held for 4 cycles, all reads -> grants alternate 01, 10, 01, 10; each rvalid_o matches the previous cycle's grant.
- Partial write: addr 3 = 0xFF, then write 0x00 with be 0x0F, then read -> 0xF0.
- sleep_en_i = 1, IDLE_CYCLES = 16, no requests -> mem_power_sleep_o rises on cycle 17.
- Then req_i = 01 -> WAKE for 4 cycles with gnt_o = 0, followed by a grant in the first ACTIVE cycle.
- Reset asserted in the cycle after a read grant -> rvalid_o = 0, pointer = 0, state ACTIVE.
- Idle threshold reached with a request in the same cycle -> stays ACTIVE and the request is granted.

Source files
------------

// File: rtl/sne_sram_arb_pkg.sv
// Shared types and default parameters for the SRAM arbiter.
package sne_sram_arb_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } sram_arb_state_e;

  localparam int unsigned DEF_NUM_REQ     = 2;
  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_NUM_WORDS   = 32;
  localparam int unsigned DEF_IDLE_CYCLES = 16;
  localparam int unsigned DEF_WAKE_CYCLES = 4;

endpackage

// File: rtl/sne_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the
// pointer, wrapping from N-1 back to 0.
//   i_req  : request vector
//   i_ptr  : highest-priority index for this cycle
//   o_gnt  : one-hot grant (all zero when no request)
//   o_idx  : index of the granted requester (0 when no request)
module sne_rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic              w_found;
  logic [PW-1:0]     w_k;
  int unsigned       w_j;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    w_k     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_j = (int'(i_ptr) + i) % N;
      w_k = PW'(w_j);
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/sne_sram_arbiter.sv
// Round-robin sharing of one single-port SRAM between NUM_REQ requesters,
// with registered read-valid return and automatic sleep/wake sequencing.
//   clk_i, rst_i            : clock, async active-high reset
//   sleep_en_i              : allow automatic sleep entry
//   req/we/addr/wdata/be_i  : per-requester access payload
//   gnt_o                   : one-hot grant (combinational)
//   rvalid_o, rdata_o       : read return (rvalid registered, rdata pass-through)
//   sleeping_o              : high in SLEEP and WAKE
//   mem_*                   : SRAM-side access and power controls
module sne_sram_arbiter
  import sne_sram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter  int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_WORDS   = DEF_NUM_WORDS,
  parameter  int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter  int unsigned WAKE_CYCLES = DEF_WAKE_CYCLES,
  localparam int unsigned ADDR_WIDTH  = $clog2(NUM_WORDS)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 sleep_en_i,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   be_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 sleeping_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  output logic [DATA_WIDTH-1:0]                mem_be_o,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
  output logic                                 mem_power_sleep_o,
  output logic                                 mem_power_gate_o
);

  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WAKE_W = $clog2(WAKE_CYCLES + 1);

  sram_arb_state_e     r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nxt, w_idx;
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic [WAKE_W-1:0]   r_wake, w_wake_nxt, w_wake_inc;
  logic [NUM_REQ-1:0]  r_rvalid, w_req_act, w_gnt;
  logic                r_sleep, r_sleeping, w_any;

  // Grants only while ACTIVE; requests in SLEEP/WAKE wait at the requester.
  assign w_req_act = (r_state == ACTIVE) ? req_i : '0;

  sne_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req (w_req_act),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_any     = |w_gnt;
  assign w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);

  assign gnt_o             = w_gnt;
  assign mem_req_o         = w_any;
  assign mem_we_o          = w_any & we_i[w_idx];
  assign mem_addr_o        = addr_i[w_idx];
  assign mem_wdata_o       = wdata_i[w_idx];
  assign mem_be_o          = be_i[w_idx];
  assign rdata_o           = mem_rdata_i;
  assign rvalid_o          = r_rvalid;
  assign sleeping_o        = r_sleeping;
  assign mem_power_sleep_o = r_sleep;
  assign mem_power_gate_o  = 1'b0;

  // Idle count: cleared by any request or pending read return, saturating.
  always_comb begin
    w_idle_nxt = r_idle;
    if ((r_state != ACTIVE) || (|req_i) || (|r_rvalid)) begin
      w_idle_nxt = '0;
    end else if (r_idle != IDLE_W'(IDLE_CYCLES)) begin
      w_idle_nxt = r_idle + IDLE_W'(1);
    end
  end

  assign w_wake_inc = r_wake + WAKE_W'(1);

  // Next state; sleep entry compares the updated idle count so a request
  // arriving at the threshold cycle blocks it.
  always_comb begin
    w_state_nxt = r_state;
    w_wake_nxt  = '0;
    case (r_state)
      ACTIVE: begin
        if (sleep_en_i && (w_idle_nxt == IDLE_W'(IDLE_CYCLES))) begin
          w_state_nxt = SLEEP;
        end
      end
      SLEEP: begin
        if ((|req_i) || !sleep_en_i) begin
          w_state_nxt = WAKE;
        end
      end
      WAKE: begin
        if (w_wake_inc == WAKE_W'(WAKE_CYCLES)) begin
          w_state_nxt = ACTIVE;
        end else begin
          w_wake_nxt = w_wake_inc;
        end
      end
      default: w_state_nxt = ACTIVE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ACTIVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pointer, counters, read-valid and power outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_idle     <= '0;
      r_wake     <= '0;
      r_rvalid   <= '0;
      r_sleep    <= 1'b0;
      r_sleeping <= 1'b0;
    end else begin
      r_idle     <= w_idle_nxt;
      r_wake     <= w_wake_nxt;
      r_rvalid   <= (w_any && !we_i[w_idx]) ? w_gnt : '0;
      r_sleep    <= (w_state_nxt == SLEEP);
      r_sleeping <= (w_state_nxt != ACTIVE);
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sne_sram_arbiter.sv
// Directed bench for sne_sram_arbiter with a behavioural one-cycle-latency
// bit-enable SRAM attached to the memory port.
module tb_sne_sram_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic            sleep_en;
  logic [1:0]      req, we, gnt, rvalid;
  logic [1:0][4:0] addr;
  logic [1:0][7:0] wdata, be;
  logic [7:0]      rdata, mem_wdata, mem_be, sram_rdata;
  logic [4:0]      mem_addr;
  logic            sleeping, mem_req, mem_we, mem_psleep, mem_pgate;
  logic [7:0]      mem [0:31];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sne_sram_arbiter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .sleep_en_i        (sleep_en),
    .req_i             (req),
    .we_i              (we),
    .addr_i            (addr),
    .wdata_i           (wdata),
    .be_i              (be),
    .gnt_o             (gnt),
    .rvalid_o          (rvalid),
    .rdata_o           (rdata),
    .sleeping_o        (sleeping),
    .mem_req_o         (mem_req),
    .mem_we_o          (mem_we),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_be_o          (mem_be),
    .mem_rdata_i       (sram_rdata),
    .mem_power_sleep_o (mem_psleep),
    .mem_power_gate_o  (mem_pgate)
  );

  always_ff @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr] <= (mem[mem_addr] & ~mem_be) | (mem_wdata & mem_be);
      else        sram_rdata    <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sleep_en = 1'b0; req = '0; we = '0;
    addr = '0; wdata = '0; be = '0;
    tick(); tick();
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_sleeping", 32'(sleeping), 0);
    chk("rst_psleep", 32'(mem_psleep), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_pgate", 32'(mem_pgate), 0);
    rst = 1'b0;
    tick();

    // Requester 0: write 5=A5, write 3=FF, partial write 3 with 00/be 0F.
    req = 2'b01; we = 2'b01; addr[0] = 5'd5; wdata[0] = 8'hA5; be[0] = 8'hFF;
    #1;
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_mem_req", 32'(mem_req), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 5);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    tick();
    addr[0] = 5'd3; wdata[0] = 8'hFF; be[0] = 8'hFF;
    #1 chk("wr3_gnt", 32'(gnt), 32'h1);
    tick();
    chk("wr_no_rvalid", 32'(rvalid), 0);
    wdata[0] = 8'h00; be[0] = 8'h0F;
    #1 chk("wr3p_be", 32'(mem_be), 32'h0F);
    tick();
    // Read 3, then back-to-back read 5.
    we = 2'b00;
    #1 chk("rd3_gnt", 32'(gnt), 32'h1);
    tick();
    chk("rd3_rvalid", 32'(rvalid), 32'h1);
    chk("rd3_rdata", 32'(rdata), 32'hF0);
    addr[0] = 5'd5;
    #1;
    chk("rd5_gnt", 32'(gnt), 32'h1);
    chk("rd3_rdata_held", 32'(rdata), 32'hF0);
    tick();
    req = 2'b00;
    chk("rd5_rvalid", 32'(rvalid), 32'h1);
    chk("rd5_rdata", 32'(rdata), 32'hA5);
    // Reset in the cycle after a read grant; pointer is 1 at this point.
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(rvalid), 0);
    chk("midrst_sleeping", 32'(sleeping), 0);
    tick();
    rst = 1'b0;
    tick();

    // Both requesters read; pointer restarts at 0 so grants go 01,10,01,10.
    req = 2'b11; we = 2'b00; addr[0] = 5'd5; addr[1] = 5'd3;
    #1 chk("rr_gnt0", 32'(gnt), 32'h1);
    tick();
    chk("rr_gnt1", 32'(gnt), 32'h2);
    chk("rr_rv0", 32'(rvalid), 32'h1);
    chk("rr_rd0", 32'(rdata), 32'hA5);
    tick();
    chk("rr_gnt2", 32'(gnt), 32'h1);
    chk("rr_rv1", 32'(rvalid), 32'h2);
    chk("rr_rd1", 32'(rdata), 32'hF0);
    tick();
    chk("rr_gnt3", 32'(gnt), 32'h2);
    chk("rr_rv2", 32'(rvalid), 32'h1);
    chk("rr_rd2", 32'(rdata), 32'hA5);
    tick();
    req = 2'b00;
    chk("rr_rv3", 32'(rvalid), 32'h2);
    chk("rr_rd3", 32'(rdata), 32'hF0);
    tick();
    chk("rr_rv_done", 32'(rvalid), 0);

    // Sleep entry from reset: power_sleep rises in cycle 17.
    rst = 1'b1; sleep_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("c16_psleep", 32'(mem_psleep), 0);
    tick();
    chk("c17_psleep", 32'(mem_psleep), 1);
    chk("c17_sleeping", 32'(sleeping), 1);
    tick();
    chk("sleep_gnt", 32'(gnt), 0);
    // Request wakes the SRAM; four WAKE cycles with no grant.
    req = 2'b01; we = 2'b00; addr[0] = 5'd3;
    #1;
    chk("sleep_req_gnt", 32'(gnt), 0);
    chk("sleep_mem_req", 32'(mem_req), 0);
    tick();
    chk("w1_psleep", 32'(mem_psleep), 0);
    chk("w1_sleeping", 32'(sleeping), 1);
    chk("w1_gnt", 32'(gnt), 0);
    sleep_en = 1'b0;
    tick();
    chk("w2_gnt", 32'(gnt), 0);
    sleep_en = 1'b1;
    tick();
    chk("w3_gnt", 32'(gnt), 0);
    tick();
    chk("w4_gnt", 32'(gnt), 0);
    chk("w4_sleeping", 32'(sleeping), 1);
    tick();
    chk("act_sleeping", 32'(sleeping), 0);
    chk("act_gnt", 32'(gnt), 32'h1);
    chk("act_mem_req", 32'(mem_req), 1);
    tick();
    req = 2'b00;
    chk("act_rvalid", 32'(rvalid), 32'h1);
    chk("act_rdata", 32'(rdata), 32'hF0);

    // Request arrives in the cycle the idle count would reach threshold.
    rst = 1'b1; sleep_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    req = 2'b01; we = 2'b00; addr[0] = 5'd5;
    #1 chk("thr_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    chk("thr_psleep", 32'(mem_psleep), 0);
    chk("thr_sleeping", 32'(sleeping), 0);
    chk("thr_rvalid", 32'(rvalid), 32'h1);
    chk("thr_rdata", 32'(rdata), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
